ip_codma_read_machine: RTL and testbench

IP_CODMA_READ_MACHINE -- requirements
Module: ip_codma_read_machine

---
 rtl/ip_codma_read_machine.sv | 179 +++++++++++++++++
 tb/tb_ip_codma_read_machine.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_codma_read_machine.sv
// CODMA read engine: fetches one 1/2/4-beat 64-bit burst into an
// 8-word buffer, with alignment checks, abort and a progress watchdog.
package ip_codma_states_pkg;
    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_ASK     = 2'd1,
        RD_GRANTED = 2'd2,
        RD_ERROR   = 2'd3
    } read_state_t;
endpackage

module ip_codma_read_machine
    import ip_codma_states_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             stop_i,
    input  logic             need_read_i,
    input  logic [31:0]      reg_addr,
    input  logic [7:0]       reg_size,
    output logic             need_read_o,
    output logic [7:0][31:0] data_reg,
    output read_state_t      rd_state_r,
    output read_state_t      rd_state_next_s,
    output logic             rd_state_error,
    output logic             bus_req_o,
    output logic [31:0]      bus_addr_o,
    output logic [7:0]       bus_size_o,
    input  logic             bus_gnt_i,
    input  logic             bus_rvalid_i,
    input  logic [63:0]      bus_rdata_i,
    input  logic             bus_error_i
);

    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_CYCLES);

    read_state_t      state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [7:0]       size_q, size_d;
    logic [2:0]       beats_q, beats_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0][31:0] data_q, data_d;
    logic [7:0]       wdog_q, wdog_d;
    logic             hold_q, hold_d;

    logic [2:0]       req_beats;
    logic             req_ok;
    logic [7:0]       wdog_inc;
    logic             last_beat;
    logic [2:0]       widx;

    always_comb begin
        req_beats = 3'd0;
        case (reg_size)
            8'd3:    req_beats = 3'd1;
            8'd8:    req_beats = 3'd2;
            8'd9:    req_beats = 3'd4;
            default: req_beats = 3'd0;
        endcase
    end

    assign req_ok    = (req_beats != 3'd0) && (reg_addr[2:0] == 3'b000);
    assign wdog_inc  = wdog_q + 8'd1;
    assign last_beat = (({1'b0, idx_q} + 3'd1) == beats_q);
    assign widx      = {idx_q, 1'b0};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        beats_d     = beats_q;
        idx_d       = idx_q;
        data_d      = data_q;
        wdog_d      = wdog_q;
        hold_d      = 1'b0;
        need_read_o = need_read_i;

        unique case (state_q)
            RD_IDLE: begin
                // hold_q blocks a restart in the first cycle back in idle
                if (need_read_i && !hold_q) begin
                    if (req_ok) begin
                        state_d = RD_ASK;
                        addr_d  = reg_addr;
                        size_d  = reg_size;
                        beats_d = req_beats;
                        idx_d   = 2'd0;
                        data_d  = '0;
                    end else begin
                        state_d = RD_ERROR;
                    end
                end
            end
            RD_ASK: begin
                if (bus_error_i) begin
                    state_d = RD_ERROR;
                end else if (bus_gnt_i) begin
                    state_d = RD_GRANTED;
                    wdog_d  = 8'd0;
                end else if (wdog_inc == WDOG_LIMIT) begin
                    state_d = RD_ERROR;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            RD_GRANTED: begin
                if (bus_error_i) begin
                    state_d = RD_ERROR;
                end else if (bus_rvalid_i) begin
                    data_d[widx]        = bus_rdata_i[31:0];
                    data_d[widx + 3'd1] = bus_rdata_i[63:32];
                    idx_d               = idx_q + 2'd1;
                    wdog_d              = 8'd0;
                    if (last_beat) begin
                        state_d     = RD_IDLE;
                        need_read_o = 1'b0;
                    end
                end else if (wdog_inc == WDOG_LIMIT) begin
                    state_d = RD_ERROR;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            RD_ERROR: begin
                need_read_o = 1'b0;
                state_d     = RD_IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle beat or error
        if (stop_i) begin
            state_d     = RD_IDLE;
            addr_d      = addr_q;
            size_d      = size_q;
            beats_d     = beats_q;
            idx_d       = idx_q;
            data_d      = data_q;
            need_read_o = (state_q == RD_ERROR) ? 1'b0 : need_read_i;
        end

        if (state_d != state_q) begin
            wdog_d = 8'd0;
        end
        hold_d = (state_q != RD_IDLE) && (state_d == RD_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= RD_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            beats_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            wdog_q  <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            beats_q <= beats_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            wdog_q  <= wdog_d;
            hold_q  <= hold_d;
        end
    end

    assign rd_state_r      = state_q;
    assign rd_state_next_s = state_d;
    assign rd_state_error  = (state_q == RD_ERROR);
    assign bus_req_o       = (state_q == RD_ASK);
    assign bus_addr_o      = addr_q;
    assign bus_size_o      = size_q;
    assign data_reg        = data_q;

endmodule

// File: tb/tb_ip_codma_read_machine.sv
// Randomized bench for ip_codma_read_machine against a
// transaction-level model of burst outcome and buffer contents.
module tb_ip_codma_read_machine;
    import ip_codma_states_pkg::*;

    logic             clk_i;
    logic             reset_n_i;
    logic             stop_i;
    logic             need_read_i;
    logic [31:0]      reg_addr;
    logic [7:0]       reg_size;
    logic             need_read_o;
    logic [7:0][31:0] data_reg;
    read_state_t      rd_state_r;
    read_state_t      rd_state_next_s;
    logic             rd_state_error;
    logic             bus_req_o;
    logic [31:0]      bus_addr_o;
    logic [7:0]       bus_size_o;
    logic             bus_gnt_i;
    logic             bus_rvalid_i;
    logic [63:0]      bus_rdata_i;
    logic             bus_error_i;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] mdl_data [8];

    ip_codma_read_machine #(.TIMEOUT_CYCLES(255)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .stop_i          (stop_i),
        .need_read_i     (need_read_i),
        .reg_addr        (reg_addr),
        .reg_size        (reg_size),
        .need_read_o     (need_read_o),
        .data_reg        (data_reg),
        .rd_state_r      (rd_state_r),
        .rd_state_next_s (rd_state_next_s),
        .rd_state_error  (rd_state_error),
        .bus_req_o       (bus_req_o),
        .bus_addr_o      (bus_addr_o),
        .bus_size_o      (bus_size_o),
        .bus_gnt_i       (bus_gnt_i),
        .bus_rvalid_i    (bus_rvalid_i),
        .bus_rdata_i     (bus_rdata_i),
        .bus_error_i     (bus_error_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        #4;
    endtask

    task automatic check_data(input string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_w%0d", tag, i), data_reg[i], mdl_data[i]);
    endtask

    task automatic clear_inputs();
        stop_i       = 1'b0;
        need_read_i  = 1'b0;
        reg_addr     = '0;
        reg_size     = '0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        bus_error_i  = 1'b0;
    endtask

    task automatic finish_trial();
        clear_inputs();
        step();
        step();
    endtask

    // After an abort: idle, no pulse, buffer kept, no restart this cycle
    task automatic after_abort(input string tag);
        stop_i       = 1'b0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_error_i  = 1'b0;
        sample();
        check({tag, "_state"}, rd_state_r, RD_IDLE);
        check({tag, "_noerr"}, rd_state_error, 1'b0);
        check({tag, "_req"}, bus_req_o, 1'b0);
        check({tag, "_hold"}, rd_state_next_s, RD_IDLE);
        check_data(tag);
    endtask

    task automatic run_trial(input logic [31:0] addr, input logic [7:0] size,
                             input int gdel, input int err_beat,
                             input int stop_at, input bit dense,
                             input bit use_first, input logic [63:0] first_beat);
        int nb;
        bit ok;
        int k;
        int cyc;
        int gap;
        bit done;
        logic [63:0] beat;
        logic [31:0] r0;
        logic [31:0] r1;

        nb = (size == 8'd3) ? 1 : (size == 8'd8) ? 2 : (size == 8'd9) ? 4 : 0;
        ok = (nb != 0) && (addr[2:0] == 3'b000);

        need_read_i = 1'b1;
        reg_addr    = addr;
        reg_size    = size;
        sample();
        check("req_state", rd_state_r, RD_IDLE);
        check("req_next", rd_state_next_s, ok ? RD_ASK : RD_ERROR);
        check("req_busreq", bus_req_o, 1'b0);
        step();

        if (!ok) begin
            sample();
            check("err_state", rd_state_r, RD_ERROR);
            check("err_pulse", rd_state_error, 1'b1);
            check("err_need", need_read_o, 1'b0);
            check("err_req", bus_req_o, 1'b0);
            check("err_next", rd_state_next_s, RD_IDLE);
            step();
            sample();
            check("err_gone", rd_state_error, 1'b0);
            check("err_hold", rd_state_next_s, RD_IDLE);
            check("err_req2", bus_req_o, 1'b0);
            check_data("err_data");
            finish_trial();
            return;
        end

        for (int i = 0; i < 8; i++) mdl_data[i] = 32'd0;
        cyc = 0;
        for (int c = 0; c <= gdel; c++) begin
            bus_gnt_i = (c == gdel);
            stop_i    = (cyc == stop_at);
            sample();
            check("ask_state", rd_state_r, RD_ASK);
            check("ask_req", bus_req_o, 1'b1);
            check("ask_addr", bus_addr_o, addr);
            check("ask_size", bus_size_o, size);
            if (c == 0) check_data("ask_clr");
            if (stop_i) begin
                check("ask_stop_next", rd_state_next_s, RD_IDLE);
                step();
                after_abort("ask_stop");
                finish_trial();
                return;
            end
            check("ask_next", rd_state_next_s,
                  bus_gnt_i ? RD_GRANTED : RD_ASK);
            cyc++;
            step();
        end
        bus_gnt_i = 1'b0;

        k    = 0;
        gap  = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            r0 = $urandom;
            r1 = $urandom;
            bus_rvalid_i = dense || (gap >= 3) || ($urandom_range(2) != 0);
            if (use_first && k == 0) beat = first_beat;
            else if (dense) beat = {32'h1000_0000 + 32'(k + 1), 32'(k + 1)};
            else beat = {r1, r0};
            bus_rdata_i = beat;
            bus_error_i = bus_rvalid_i && (k == err_beat);
            stop_i      = (cyc == stop_at);
            sample();
            check("gr_state", rd_state_r, RD_GRANTED);
            check("gr_req", bus_req_o, 1'b0);
            if (stop_i) begin
                check("gr_stop_next", rd_state_next_s, RD_IDLE);
                check("gr_stop_need", need_read_o, 1'b1);
                step();
                after_abort("gr_stop");
                done = 1'b1;
            end else if (bus_error_i) begin
                check("be_next", rd_state_next_s, RD_ERROR);
                step();
                bus_rvalid_i = 1'b0;
                bus_error_i  = 1'b0;
                sample();
                check("be_state", rd_state_r, RD_ERROR);
                check("be_pulse", rd_state_error, 1'b1);
                check("be_need", need_read_o, 1'b0);
                check("be_req", bus_req_o, 1'b0);
                check("be_next2", rd_state_next_s, RD_IDLE);
                step();
                sample();
                check("be_idle", rd_state_r, RD_IDLE);
                check("be_gone", rd_state_error, 1'b0);
                check_data("be_data");
                done = 1'b1;
            end else if (bus_rvalid_i) begin
                mdl_data[2*k]   = beat[31:0];
                mdl_data[2*k+1] = beat[63:32];
                k++;
                if (k == nb) begin
                    check("fin_need", need_read_o, 1'b0);
                    check("fin_next", rd_state_next_s, RD_IDLE);
                    step();
                    r0 = $urandom;
                    bus_rdata_i  = {r0, ~r0};
                    bus_rvalid_i = 1'b1;
                    sample();
                    check("done_state", rd_state_r, RD_IDLE);
                    check("done_need", need_read_o, 1'b1);
                    check("done_hold", rd_state_next_s, RD_IDLE);
                    check("done_noerr", rd_state_error, 1'b0);
                    check_data("done_data");
                    step();
                    need_read_i  = 1'b0;
                    bus_rvalid_i = 1'b0;
                    sample();
                    check_data("stable_data");
                    done = 1'b1;
                end else begin
                    check("beat_need", need_read_o, 1'b1);
                    check("beat_next", rd_state_next_s, RD_GRANTED);
                end
            end else begin
                check("wait_need", need_read_o, 1'b1);
                check("wait_next", rd_state_next_s, RD_GRANTED);
            end
            if (!done) begin
                gap = bus_rvalid_i ? 0 : gap + 1;
                cyc++;
                step();
            end
        end
        if (!done) check("burst_budget", 1'b0, 1'b1);
        finish_trial();
    endtask

    task automatic timeout_test();
        int cnt;
        need_read_i = 1'b1;
        reg_addr    = 32'h40;
        reg_size    = 8'd8;
        sample();
        step();
        for (int i = 0; i < 8; i++) mdl_data[i] = 32'd0;
        cnt = 0;
        while (rd_state_r == RD_ASK && cnt < 300) begin
            cnt++;
            step();
        end
        check("to_cycles", 64'(cnt), 64'd255);
        sample();
        check("to_state", rd_state_r, RD_ERROR);
        check("to_pulse", rd_state_error, 1'b1);
        check("to_req", bus_req_o, 1'b0);
        step();
        sample();
        check("to_idle", rd_state_r, RD_IDLE);
        finish_trial();
    endtask

    task automatic reset_mid_burst();
        need_read_i = 1'b1;
        reg_addr    = 32'h200;
        reg_size    = 8'd9;
        sample();
        step();
        bus_gnt_i = 1'b1;
        sample();
        step();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 64'hDEAD_BEEF_0BAD_F00D;
        sample();
        step();
        bus_rvalid_i = 1'b0;
        sample();
        check("rst_pre_state", rd_state_r, RD_GRANTED);
        reset_n_i = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) mdl_data[i] = 32'd0;
        check("rst_state", rd_state_r, RD_IDLE);
        check("rst_req", bus_req_o, 1'b0);
        check("rst_addr", bus_addr_o, 32'd0);
        check("rst_size", bus_size_o, 8'd0);
        check("rst_err", rd_state_error, 1'b0);
        check_data("rst_data");
        need_read_i = 1'b0;
        step();
        reset_n_i    = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 64'h1234_5678_9ABC_DEF0;
        sample();
        check("rst_idle", rd_state_r, RD_IDLE);
        step();
        sample();
        check("rst_late_state", rd_state_r, RD_IDLE);
        check_data("rst_late");
        finish_trial();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        clear_inputs();
        reset_n_i = 1'b0;
        for (int i = 0; i < 8; i++) mdl_data[i] = 32'd0;
        #1;
        check("init_state", rd_state_r, RD_IDLE);
        check("init_req", bus_req_o, 1'b0);
        check("init_addr", bus_addr_o, 32'd0);
        check("init_size", bus_size_o, 8'd0);
        check("init_err", rd_state_error, 1'b0);
        check_data("init");
        step();
        step();
        reset_n_i = 1'b1;
        step();

        run_trial(32'h1000, 8'd9, 2, -1, -1, 1'b1, 1'b0, 64'd0);
        check("seq_w0", data_reg[0], 32'h0000_0001);
        check("seq_w6", data_reg[6], 32'h0000_0004);
        check("seq_w7", data_reg[7], 32'h1000_0004);

        run_trial(32'h20, 8'd3, 1, -1, -1, 1'b1, 1'b1,
                  64'hAABB_CCDD_1122_3344);
        check("one_w0", data_reg[0], 32'h1122_3344);
        check("one_w1", data_reg[1], 32'hAABB_CCDD);
        check("one_w2", data_reg[2], 32'd0);
        check("one_w7", data_reg[7], 32'd0);

        run_trial(32'h40, 8'd5, 0, -1, -1, 1'b1, 1'b0, 64'd0);
        run_trial(32'h1004, 8'd9, 0, -1, -1, 1'b1, 1'b0, 64'd0);
        run_trial(32'h80, 8'd9, 0, 1, -1, 1'b1, 1'b0, 64'd0);
        run_trial(32'h100, 8'd9, 1, -1, 3, 1'b1, 1'b0, 64'd0);
        run_trial(32'h180, 8'd9, 0, 1, 2, 1'b1, 1'b0, 64'd0);
        timeout_test();
        reset_mid_burst();

        for (int t = 0; t < 40; t++) begin
            logic [31:0] r;
            logic [31:0] a;
            logic [7:0]  s;
            int sel;
            int gd;
            int eb;
            int sa;
            r   = $urandom;
            a   = {r[31:3], 3'b000};
            sel = int'($urandom_range(0, 7));
            case (sel)
                0, 1:    s = 8'd3;
                2, 3:    s = 8'd8;
                4, 5:    s = 8'd9;
                6: begin
                    r = $urandom;
                    s = r[7:0];
                    if (s == 8'd3 || s == 8'd8 || s == 8'd9) s = 8'd5;
                end
                default: begin
                    s = 8'd9;
                    a[2:0] = 3'($urandom_range(1, 7));
                end
            endcase
            gd = int'($urandom_range(0, 4));
            eb = -1;
            sa = -1;
            if ($urandom_range(0, 3) == 0) eb = int'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) sa = int'($urandom_range(0, 7));
            run_trial(a, s, gd, eb, sa, 1'b0, 1'b0, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
